// File: rtl/ibex_l2_rf_arbiter.sv
// Single-port L2 register-file arbiter: write-first grant with a bounded write burst,
// per-port read data buffers and an ID-stage stall request.
module ibex_l2_rf_arbiter #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = 5,
  parameter int unsigned MaxWrBurst = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 rd_a_req_i,
  input  logic [AddrWidth-1:0] rd_a_addr_i,
  output logic                 rd_a_gnt_o,
  output logic                 rd_a_rvalid_o,
  output logic [DataWidth-1:0] rd_a_rdata_o,

  input  logic                 rd_b_req_i,
  input  logic [AddrWidth-1:0] rd_b_addr_i,
  output logic                 rd_b_gnt_o,
  output logic                 rd_b_rvalid_o,
  output logic [DataWidth-1:0] rd_b_rdata_o,

  input  logic                 wr_req_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [DataWidth-1:0] wr_wdata_i,
  output logic                 wr_gnt_o,

  output logic [AddrWidth-1:0] l2_addr_o,
  output logic                 l2_we_o,
  output logic [DataWidth-1:0] l2_wdata_o,
  input  logic [DataWidth-1:0] l2_rdata_i,

  output logic                 stall_o
);

  localparam int unsigned BurstWidth = 3;
  localparam logic [BurstWidth-1:0] BurstMax = BurstWidth'(MaxWrBurst);

  typedef enum logic [1:0] {
    SelNone,
    SelWr,
    SelRdA,
    SelRdB
  } l2_sel_e;

  l2_sel_e               l2_sel;
  logic                  rd_a_zero, rd_b_zero;
  logic                  rd_a_l2, rd_b_l2;
  logic                  rd_pending, burst_full;
  logic [BurstWidth-1:0] wr_burst_q, wr_burst_d;

  logic                  rd_a_rvalid_q, rd_b_rvalid_q;
  logic [DataWidth-1:0]  rd_a_rdata_q, rd_b_rdata_q;

  // Request classification; everything is masked while reset is asserted.
  always_comb begin
    rd_a_zero  = rst_ni && rd_a_req_i && (rd_a_addr_i == '0);
    rd_b_zero  = rst_ni && rd_b_req_i && (rd_b_addr_i == '0);
    rd_a_l2    = rst_ni && rd_a_req_i && (rd_a_addr_i != '0);
    rd_b_l2    = rst_ni && rd_b_req_i && (rd_b_addr_i != '0);
    rd_pending = rd_a_req_i || rd_b_req_i;
    burst_full = (wr_burst_q == BurstMax) && (rd_a_l2 || rd_b_l2);
  end

  // One L2 slot per cycle: write first unless the burst budget is spent.
  always_comb begin
    l2_sel = SelNone;
    if (rst_ni && wr_req_i && !burst_full) begin
      l2_sel = SelWr;
    end else if (rd_a_l2) begin
      l2_sel = SelRdA;
    end else if (rd_b_l2) begin
      l2_sel = SelRdB;
    end
  end

  assign rd_a_gnt_o = rd_a_zero || (l2_sel == SelRdA);
  assign rd_b_gnt_o = rd_b_zero || (l2_sel == SelRdB);
  assign wr_gnt_o   = (l2_sel == SelWr);

  // L2 port mux; address-0 writes keep the slot but never assert the write enable.
  always_comb begin
    l2_addr_o  = '0;
    l2_we_o    = 1'b0;
    l2_wdata_o = '0;
    unique case (l2_sel)
      SelWr: begin
        l2_addr_o  = wr_addr_i;
        l2_we_o    = (wr_addr_i != '0);
        l2_wdata_o = wr_wdata_i;
      end
      SelRdA:  l2_addr_o = rd_a_addr_i;
      SelRdB:  l2_addr_o = rd_b_addr_i;
      default: l2_addr_o = '0;
    endcase
  end

  // Stall while anything waits, or while L2 read data is still in flight.
  always_comb begin
    stall_o = 1'b0;
    if (rst_ni) begin
      stall_o = (rd_a_req_i && !rd_a_gnt_o) ||
                (rd_b_req_i && !rd_b_gnt_o) ||
                (wr_req_i   && !wr_gnt_o)   ||
                (l2_sel == SelRdA) || (l2_sel == SelRdB);
    end
  end

  always_comb begin
    wr_burst_d = wr_burst_q;
    if (rd_a_gnt_o || rd_b_gnt_o || !rd_pending) begin
      wr_burst_d = '0;
    end else if (wr_gnt_o) begin
      wr_burst_d = wr_burst_q + BurstWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_burst_q    <= '0;
      rd_a_rvalid_q <= 1'b0;
      rd_b_rvalid_q <= 1'b0;
      rd_a_rdata_q  <= '0;
      rd_b_rdata_q  <= '0;
    end else begin
      wr_burst_q    <= wr_burst_d;
      rd_a_rvalid_q <= rd_a_gnt_o;
      rd_b_rvalid_q <= rd_b_gnt_o;
      if (rd_a_gnt_o) begin
        rd_a_rdata_q <= rd_a_zero ? '0 : l2_rdata_i;
      end
      if (rd_b_gnt_o) begin
        rd_b_rdata_q <= rd_b_zero ? '0 : l2_rdata_i;
      end
    end
  end

  assign rd_a_rvalid_o = rd_a_rvalid_q;
  assign rd_b_rvalid_o = rd_b_rvalid_q;
  assign rd_a_rdata_o  = rd_a_rdata_q;
  assign rd_b_rdata_o  = rd_b_rdata_q;

endmodule

// File: tb/tb_ibex_l2_rf_arbiter.sv
// Scoreboard bench for ibex_l2_rf_arbiter: a rule-level model predicts each cycle's
// grants and read data; a forked monitor compares them against the DUT.
module tb_ibex_l2_rf_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned MAX = 2;

  typedef struct packed {
    logic          ga, gb, gw, rva, rvb, stall, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          rd_a_req = 1'b0, rd_b_req = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] rd_a_addr = '0, rd_b_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_wdata = '0;
  logic          rd_a_gnt, rd_a_rvalid, rd_b_gnt, rd_b_rvalid, wr_gnt, l2_we, stall;
  logic [DW-1:0] rd_a_rdata, rd_b_rdata, l2_wdata, l2_rdata;
  logic [AW-1:0] l2_addr;

  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] mem [32];

  int total = 0, bad = 0;

  exp_t          cyc_q[$];
  logic [DW-1:0] rda_q[$], rdb_q[$];
  int            hist[$];
  logic [DW-1:0] ref_regs [32];
  int            writes_in_row = 0;
  logic          last_ga = 0, last_gb = 0, last_gw = 0;

  always #5 clk = ~clk;

  ibex_l2_rf_arbiter #(.DataWidth(DW), .AddrWidth(AW), .MaxWrBurst(MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_a_req_i(rd_a_req), .rd_a_addr_i(rd_a_addr), .rd_a_gnt_o(rd_a_gnt),
    .rd_a_rvalid_o(rd_a_rvalid), .rd_a_rdata_o(rd_a_rdata),
    .rd_b_req_i(rd_b_req), .rd_b_addr_i(rd_b_addr), .rd_b_gnt_o(rd_b_gnt),
    .rd_b_rvalid_o(rd_b_rvalid), .rd_b_rdata_o(rd_b_rdata),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_wdata_i(wr_wdata), .wr_gnt_o(wr_gnt),
    .l2_addr_o(l2_addr), .l2_we_o(l2_we), .l2_wdata_o(l2_wdata), .l2_rdata_i(l2_rdata),
    .stall_o(stall)
  );

  // L2 array: combinational read, write at the clock edge, plus a preload port.
  always_comb l2_rdata = mem[l2_addr];
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (l2_we) mem[l2_addr] <= l2_wdata;
  end

  function automatic logic [107:0] all_outs();
    return {rd_a_gnt, rd_a_rvalid, rd_a_rdata, rd_b_gnt, rd_b_rvalid, rd_b_rdata,
            wr_gnt, l2_addr, l2_we, l2_wdata, stall};
  endfunction

  // Reference model for one cycle: inputs are already applied; push expectations.
  task automatic step();
    exp_t e;
    logic a_z, b_z, a_l2, b_l2, starve, ga, gb, gw;
    int   win;
    a_z    = rd_a_req && (rd_a_addr == 0);
    b_z    = rd_b_req && (rd_b_addr == 0);
    a_l2   = rd_a_req && !a_z;
    b_l2   = rd_b_req && !b_z;
    starve = (writes_in_row >= int'(MAX)) && (a_l2 || b_l2);
    if (wr_req && !starve) win = 1;
    else if (a_l2)         win = 2;
    else if (b_l2)         win = 3;
    else                   win = 0;
    ga = a_z || (win == 2);
    gb = b_z || (win == 3);
    gw = (win == 1);
    if (ga) rda_q.push_back(a_z ? '0 : ref_regs[rd_a_addr]);
    if (gb) rdb_q.push_back(b_z ? '0 : ref_regs[rd_b_addr]);
    e.ga    = ga;
    e.gb    = gb;
    e.gw    = gw;
    e.rva   = last_ga;
    e.rvb   = last_gb;
    e.stall = (rd_a_req && !ga) || (rd_b_req && !gb) || (wr_req && !gw) || win == 2 || win == 3;
    e.we    = gw && (wr_addr != 0);
    e.addr  = (win == 1) ? wr_addr : (win == 2) ? rd_a_addr : (win == 3) ? rd_b_addr : '0;
    e.wdata = gw ? wr_wdata : '0;
    cyc_q.push_back(e);
    hist.push_back(win);
    if (e.we) ref_regs[wr_addr] = wr_wdata;
    if (ga || gb || !(rd_a_req || rd_b_req)) writes_in_row = 0;
    else if (gw) writes_in_row++;
    last_ga = ga;
    last_gb = gb;
    last_gw = gw;
    @(posedge clk); #1;
  endtask

  task automatic drop_granted();
    if (last_ga) rd_a_req = 1'b0;
    if (last_gb) rd_b_req = 1'b0;
    if (last_gw) wr_req   = 1'b0;
  endtask

  // Run until every held request is served, then one idle cycle.
  task automatic serve();
    for (int n = 0; n < 20 && (rd_a_req || rd_b_req || wr_req); n++) begin
      step();
      drop_granted();
    end
    rd_a_req = 1'b0; rd_b_req = 1'b0; wr_req = 1'b0;
    step();
  endtask

  task automatic monitor();
    exp_t          e, act;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cyc_q.size() > 0) begin
          e   = cyc_q.pop_front();
          act = '{ga: rd_a_gnt, gb: rd_b_gnt, gw: wr_gnt, rva: rd_a_rvalid, rvb: rd_b_rvalid,
                  stall: stall, we: l2_we, addr: l2_addr, wdata: l2_wdata};
          total++;
          if (act !== e) begin
            bad++;
            $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, act, e);
          end
        end
        if (rd_a_rvalid) begin
          total++;
          if (rda_q.size() == 0) begin
            bad++;
            $display("FAIL rdata_a_spurious t=%0t got=%h want=none", $time, rd_a_rdata);
          end else begin
            d = rda_q.pop_front();
            if (rd_a_rdata !== d) begin
              bad++;
              $display("FAIL rdata_a t=%0t got=%h want=%h", $time, rd_a_rdata, d);
            end
          end
        end
        if (rd_b_rvalid) begin
          total++;
          if (rdb_q.size() == 0) begin
            bad++;
            $display("FAIL rdata_b_spurious t=%0t got=%h want=none", $time, rd_b_rdata);
          end else begin
            d = rdb_q.pop_front();
            if (rd_b_rdata !== d) begin
              bad++;
              $display("FAIL rdata_b t=%0t got=%h want=%h", $time, rd_b_rdata, d);
            end
          end
        end
      end
    end
  endtask

  initial begin
    int exp_h[4];
    fork
      monitor();
    join_none

    // Preload L2 while in reset; check outputs are quiet.
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      pl_we   = 1'b1;
      pl_addr = AW'(i);
      case (i)
        0:       pl_data = 32'hA5A5_A5A5;
        5:       pl_data = 32'hDEAD_BEEF;
        7:       pl_data = 32'h0000_0001;
        20:      pl_data = 32'h1234_5678;
        default: pl_data = $urandom;
      endcase
      ref_regs[i] = pl_data;
      @(posedge clk); #1;
    end
    pl_we = 1'b0;
    rd_a_req = 1'b1; rd_b_req = 1'b1; wr_req = 1'b1;
    #1;
    total++;
    if (all_outs() !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", all_outs());
    end
    rd_a_req = 1'b0; rd_b_req = 1'b0; wr_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Two reads together: A then B, with stall during both grants.
    rd_a_req = 1'b1; rd_a_addr = 5'd5; rd_b_req = 1'b1; rd_b_addr = 5'd20;
    serve();
    // Read-after-write to the same address in one cycle.
    wr_req = 1'b1; wr_addr = 5'd7; wr_wdata = 32'hCAFE_F00D;
    rd_a_req = 1'b1; rd_a_addr = 5'd7;
    serve();
    // Address-0 read shares the cycle with an L2 read.
    rd_a_req = 1'b1; rd_a_addr = 5'd0; rd_b_req = 1'b1; rd_b_addr = 5'd9;
    serve();
    // Write to address 0 is granted but dropped.
    wr_req = 1'b1; wr_addr = 5'd0; wr_wdata = 32'hFFFF_FFFF;
    serve();
    // All three at once: W, A, B then stall drops.
    wr_req = 1'b1; wr_addr = 5'd3; wr_wdata = $urandom;
    rd_a_req = 1'b1; rd_a_addr = 5'd3; rd_b_req = 1'b1; rd_b_addr = 5'd4;
    serve();

    // Burst limit with writes held continuously and A waiting.
    hist.delete();
    exp_h = '{1, 1, 2, 1};
    wr_req = 1'b1; wr_addr = 5'd10; wr_wdata = $urandom;
    rd_a_req = 1'b1; rd_a_addr = 5'd5;
    for (int k = 0; k < 4; k++) begin
      step();
      if (last_gw) begin
        wr_addr  = AW'(11 + k);
        wr_wdata = $urandom;
      end
      if (last_ga) rd_a_req = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (hist[k] != exp_h[k]) begin
        bad++;
        $display("FAIL burst_seq[%0d] got=%0d want=%0d", k, hist[k], exp_h[k]);
      end
    end
    serve();

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      if (!rd_a_req && ($urandom_range(2) == 0)) begin
        rd_a_req = 1'b1; rd_a_addr = ($urandom_range(3) == 0) ? AW'($urandom) : AW'($urandom_range(7));
      end
      if (!rd_b_req && ($urandom_range(2) == 0)) begin
        rd_b_req = 1'b1; rd_b_addr = ($urandom_range(3) == 0) ? AW'($urandom) : AW'($urandom_range(7));
      end
      if (!wr_req && ($urandom_range(1) == 0)) begin
        wr_req = 1'b1; wr_addr = AW'($urandom_range(7)); wr_wdata = $urandom;
      end
      step();
      drop_granted();

      // Mid-operation reset with every request high.
      if (c == 700) begin
        rd_a_req = 1'b1; rd_b_req = 1'b1; wr_req = 1'b1;
        rd_a_addr = 5'd6; rd_b_addr = 5'd2; wr_addr = 5'd6; wr_wdata = $urandom;
        #2;
        rst_n = 1'b0;
        rda_q.delete(); rdb_q.delete();
        #1;
        total++;
        if (all_outs() !== '0) begin
          bad++;
          $display("FAIL midop_reset got=%h want=0", all_outs());
        end
        rd_a_req = 1'b0; rd_b_req = 1'b0; wr_req = 1'b0;
        writes_in_row = 0; last_ga = 0; last_gb = 0; last_gw = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    end
    serve();
    step();
    @(negedge clk); #1;

    total++;
    if (rda_q.size() != 0 || rdb_q.size() != 0) begin
      bad++;
      $display("FAIL missing_rvalid got=%0d/%0d want=0/0", rda_q.size(), rdb_q.size());
    end
    total++;
    if (mem[0] !== 32'hA5A5_A5A5) begin
      bad++;
      $display("FAIL l2_addr0_untouched got=%h want=a5a5a5a5", mem[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
